// File: rtl/wakka_pkg.sv
// Shared types and constants for the wakka sound-table player.
package wakka_pkg;

  // Sample ROM geometry.
  localparam int WAKKA_ADDR_W = 9;
  localparam int WAKKA_DATA_W = 10;

  // Table layout: address 0 is a marker, playback runs from 1 up to at most 416.
  localparam int WAKKA_FIRST_ADDR = 1;
  localparam int WAKKA_LAST_ADDR  = 416;
  localparam int WAKKA_END_CODE   = 1023;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_COUNT
  } wakka_state_t;

endpackage

// File: rtl/wakka_tick_div.sv
// Duration-unit prescaler: while enabled, asserts tick for one cycle out of
// every TICK_DIV. load restarts the division from the top.
module wakka_tick_div #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int PW = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0] RELOAD = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_reg;

  // Tick on the last cycle of each TICK_DIV-cycle unit.
  assign tick = en && (cnt_reg == '0);

  // Count down while enabled, reloading on load or when a unit completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= RELOAD;
    end else if (load || tick) begin
      cnt_reg <= RELOAD;
    end else if (en) begin
      cnt_reg <= cnt_reg - PW'(1);
    end
  end

endmodule

// File: rtl/wakka_player.sv
// Square-wave sequencer for the "wakka" sound table. Walks the external
// registered sample ROM, treating each word as a half-period in tick units.
// Optional build macro WAKKA_PLAYER_LOOP_EN: with start held high, playback
// wraps back to the first entry instead of returning to idle.
module wakka_player
  import wakka_pkg::*;
#(
  parameter int ADDR_W     = WAKKA_ADDR_W,
  parameter int DATA_W     = WAKKA_DATA_W,
  parameter int FIRST_ADDR = WAKKA_FIRST_ADDR,
  parameter int LAST_ADDR  = WAKKA_LAST_ADDR,
  parameter int END_CODE   = WAKKA_END_CODE,
  parameter int TICK_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              audio,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADDR);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADDR);
  localparam logic [DATA_W-1:0] ENDW  = DATA_W'(END_CODE);
  localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);

  wakka_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] unit_reg, unit_next;
  logic              audio_reg, audio_next;
  logic              done_reg, done_next;
  logic              div_load;
  logic              div_en;
  logic              tick;
  logic              finish;

  // The prescaler only runs while a duration is being counted out.
  assign div_en = (state_reg == ST_COUNT);

  wakka_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .en   (div_en),
    .tick (tick)
  );

  // State and datapath registers; reset drops straight to idle with no done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= FIRST;
      unit_reg  <= '0;
      audio_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      unit_reg  <= unit_next;
      audio_reg <= audio_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: fetch word, load duration, count it out, toggle, advance.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    unit_next  = unit_reg;
    audio_next = audio_reg;
    done_next  = 1'b0;
    div_load   = 1'b0;
    finish     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        addr_next  = FIRST;
        audio_next = 1'b0;
        if (start) begin
          state_next = ST_FETCH;
        end
      end

      // ROM word for addr_reg appears on rom_data in the following cycle.
      ST_FETCH: begin
        state_next = ST_LOAD;
      end

      ST_LOAD: begin
        if ((rom_data == ENDW) || (rom_data == '0)) begin
          finish = 1'b1;
        end else begin
          unit_next  = rom_data;
          div_load   = 1'b1;
          state_next = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (tick) begin
          if (unit_reg == ONE) begin
            audio_next = ~audio_reg;
            if (addr_reg == LAST) begin
              finish = 1'b1;
            end else begin
              addr_next  = addr_reg + ADDR_W'(1);
              state_next = ST_FETCH;
            end
          end else begin
            unit_next = unit_reg - ONE;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // End of table: pulse done and rewind; idle entry also silences the output.
    if (finish) begin
      done_next = 1'b1;
      addr_next = FIRST;
`ifdef WAKKA_PLAYER_LOOP_EN
      if (start) begin
        state_next = ST_FETCH;
      end else begin
        state_next = ST_IDLE;
        audio_next = 1'b0;
      end
`else
      state_next = ST_IDLE;
      audio_next = 1'b0;
`endif
    end
  end

  assign rom_addr = addr_reg;
  assign audio    = audio_reg;
  assign done     = done_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_wakka_player.sv
// Scoreboard bench for wakka_player: two instances (TICK_DIV 1 and 4), each
// with a one-cycle-latency stub ROM. Expected audio edges and done pulses are
// computed from the table contents and queued; a monitor matches them.
module tb_wakka_player;

  localparam int BIG  = 32'h7fff_ffff;
  localparam int LAST = 416;
`ifdef WAKKA_PLAYER_LOOP_EN
  localparam bit LOOP_BUILD = 1'b1;
`else
  localparam bit LOOP_BUILD = 1'b0;
`endif

  typedef struct {
    int inst;
    int kind;   // 0 = audio rise, 1 = audio fall, 2 = done pulse
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start = '0;
  logic [8:0] rom_addr [2];
  logic [9:0] rom_data [2];
  logic [1:0] audio;
  logic [1:0] busy;
  logic [1:0] done;
  logic [9:0] rom_mem [2][512];

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  bit  m_aud [2];
  int  max_addr [2] = '{0, 0};
  logic [1:0] prev_aud;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int TD = (gi == 0) ? 1 : 4;

    wakka_player #(.TICK_DIV(TD)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[gi]),
      .rom_addr (rom_addr[gi]),
      .rom_data (rom_data[gi]),
      .audio    (audio[gi]),
      .busy     (busy[gi]),
      .done     (done[gi])
    );

    always @(posedge clk) rom_data[gi] <= rom_mem[gi][rom_addr[gi]];
  end

  function automatic int td_of(input int inst);
    return (inst == 0) ? 1 : 4;
  endfunction

  task automatic push_ev(input int inst, input int kind, input int c);
    ev_t e;
    e.inst = inst;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Reference: walk the table; entry N lasts N*TICK_DIV+2 cycles from its FETCH.
  // f = cycle of the first FETCH, cont = start still high at the end of the
  // pass, cut = cycle at which reset takes effect. d = cycle done is seen.
  task automatic play(input int inst, input int f, input bit cont, input int cut,
                      output int d);
    int t, te, a, td;
    bit lp, na;
    logic [9:0] w;
    td = td_of(inst);
    t  = f;
    a  = 1;
    d  = -1;
    lp = LOOP_BUILD && cont;
    forever begin
      w = rom_mem[inst][a];
      if (w == 10'd1023 || w == 10'd0) begin
        if (t + 2 >= cut) break;
        if (!lp && m_aud[inst]) push_ev(inst, 1, t + 2);
        if (!lp) m_aud[inst] = 1'b0;
        push_ev(inst, 2, t + 2);
        d = t + 2;
        return;
      end
      te = t + int'(w) * td + 2;
      if (te >= cut) break;
      na = ~m_aud[inst];
      if (a == LAST && !lp) na = 1'b0;
      if (na != m_aud[inst]) push_ev(inst, na ? 0 : 1, te);
      m_aud[inst] = na;
      if (a == LAST) begin
        push_ev(inst, 2, te);
        d = te;
        return;
      end
      a++;
      t = te;
    end
    // Reset landed mid-pass: output drops low, nothing else.
    if (m_aud[inst]) push_ev(inst, 1, cut);
    m_aud[inst] = 1'b0;
  endtask

  task automatic check_ev(input int inst, input int kind, input int c);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: actual inst=%0d kind=%0d cyc=%0d, required no event", inst, kind, c);
    end else begin
      e = exp_q.pop_front();
      if (e.inst != inst || e.kind != kind || e.cyc != c) begin
        n_fail++;
        $display("FAIL event: actual inst=%0d kind=%0d cyc=%0d, required inst=%0d kind=%0d cyc=%0d",
                 inst, kind, c, e.inst, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: every audio edge and done pulse must match the queue head.
  initial begin
    repeat (3) @(negedge clk);
    prev_aud = audio;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (audio[i] !== prev_aud[i]) check_ev(i, audio[i] ? 0 : 1, cyc);
        if (done[i] === 1'b1) check_ev(i, 2, cyc);
        if (int'(rom_addr[i]) > max_addr[i]) max_addr[i] = int'(rom_addr[i]);
        prev_aud[i] = audio[i];
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic clear_rom(input int inst);
    for (int a = 0; a < 512; a++) rom_mem[inst][a] = 10'd1023;
  endtask

  task automatic check_idle(input int inst, input string name);
    n_tests++;
    if (busy[inst] !== 1'b0 || audio[inst] !== 1'b0 || done[inst] !== 1'b0 ||
        rom_addr[inst] !== 9'd1) begin
      n_fail++;
      $display("FAIL %s inst=%0d: actual busy=%b audio=%b done=%b addr=%0d, required 0/0/0/1",
               name, inst, busy[inst], audio[inst], done[inst], rom_addr[inst]);
    end
  endtask

  task automatic check_drained(input int inst, input string name);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s inst=%0d: actual %0d expected events never seen, required 0",
               name, inst, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Issue one start request held for `hold` cycles, queueing the expected pass.
  task automatic kick(input int inst, input int hold, output int d);
    int f;
    f = cyc + 1;
    play(inst, f, 1'b0, BIG, d);
    $display("[TB] pass inst=%0d fetch_cyc=%0d done_cyc=%0d", inst, f, d);
    start[inst] = 1'b1;
    repeat (hold) @(negedge clk);
    start[inst] = 1'b0;
  endtask

  // Final done cycle: done high, busy low, audio silenced; then back to idle.
  task automatic finish_test(input int inst, input int d, input string name);
    wait_cyc(d);
    n_tests++;
    if (done[inst] !== 1'b1 || busy[inst] !== 1'b0 || audio[inst] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_cycle inst=%0d: actual done=%b busy=%b audio=%b, required 1/0/0",
               name, inst, done[inst], busy[inst], audio[inst]);
    end
    wait_cyc(d + 3);
    check_drained(inst, name);
    check_idle(inst, name);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, d1, d2, f, f2, r, inst, len;
    clear_rom(0);
    clear_rom(1);
    m_aud[0] = 1'b0;
    m_aud[1] = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_idle(0, "reset_state");
    check_idle(1, "reset_state");
    @(negedge clk);

    // Short table, TICK_DIV=1: rise 5 cycles into playback, fall 4 later.
    rom_mem[0][1] = 10'd3;
    rom_mem[0][2] = 10'd2;
    rom_mem[0][3] = 10'd1023;
    kick(0, 1, d);
    finish_test(0, d, "basic");

    // TICK_DIV=4, value 5: 22-cycle half periods.
    rom_mem[1][1] = 10'd5;
    rom_mem[1][2] = 10'd5;
    rom_mem[1][3] = 10'd1023;
    kick(1, 1, d);
    finish_test(1, d, "tickdiv4");

    // Zero word terminates; the single high half-period is cut off by idle.
    clear_rom(0);
    rom_mem[0][1] = 10'd2;
    rom_mem[0][2] = 10'd0;
    kick(0, 1, d);
    finish_test(0, d, "zero_word");

    // No terminator anywhere: must stop at the last address.
    for (int a = 1; a < 512; a++) rom_mem[0][a] = 10'd1;
    kick(0, 1, d);
    finish_test(0, d, "no_term");
    n_tests++;
    if (max_addr[0] != LAST) begin
      n_fail++;
      $display("FAIL no_term_max_addr: actual %0d, required %0d", max_addr[0], LAST);
    end

    // Reset during COUNT of address 50.
    clear_rom(0);
    for (int a = 1; a <= 60; a++) rom_mem[0][a] = 10'd3;
    f = cyc + 1;
    r = f + 49 * 5 + 3;
    play(0, f, 1'b0, r, d);
    $display("[TB] pass inst=0 fetch_cyc=%0d reset_cyc=%0d", f, r);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_cyc(r - 1);
    rst = 1'b1;
    @(negedge clk);
    check_idle(0, "mid_reset");
    rst = 1'b0;
    wait_cyc(r + 8);
    check_drained(0, "mid_reset");
    check_idle(0, "mid_reset_after");

    // start held through done: second pass follows, then release.
    clear_rom(1);
    rom_mem[1][1] = 10'd2;
    rom_mem[1][2] = 10'd3;
    f = cyc + 1;
    play(1, f, 1'b1, BIG, d1);
    f2 = LOOP_BUILD ? d1 : d1 + 1;
    play(1, f2, 1'b0, BIG, d2);
    $display("[TB] pass inst=1 fetch_cyc=%0d done_cyc=%0d then fetch_cyc=%0d done_cyc=%0d",
             f, d1, f2, d2);
    start[1] = 1'b1;
    wait_cyc(f2 + 1);
    start[1] = 1'b0;
    finish_test(1, d2, "hold_start");

    // Random tables; a 2-cycle start also exercises start-while-busy.
    for (int k = 0; k < 16; k++) begin
      inst = int'($urandom_range(0, 1));
      clear_rom(inst);
      len = int'($urandom_range(1, 6));
      for (int a = 1; a <= len; a++) rom_mem[inst][a] = 10'($urandom_range(1, 12));
      rom_mem[inst][len + 1] = ($urandom_range(0, 1) == 1) ? 10'd1023 : 10'd0;
      kick(inst, int'($urandom_range(1, 2)), d);
      finish_test(inst, d, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
